// File: rtl/ikaopll_accdac_pkg.sv
// Shared types for the accumulating-DAC controller: signed volume, per-channel
// state, volume limits and the one-step ramp helper.
package ikaopll_accdac_pkg;

    typedef logic signed [4:0] vol_t;

    typedef enum logic {
        STEADY = 1'b0,
        RAMP   = 1'b1
    } ch_state_e;

    localparam vol_t VOL_MIN = vol_t'(5'b10000);
    localparam vol_t VOL_MAX = vol_t'(5'b01111);

    // One unit toward tgt, clamped at the rails; returns cur once it equals tgt.
    function automatic vol_t step_toward(input vol_t cur, input vol_t tgt);
        if ((cur < tgt) && (cur != VOL_MAX)) return cur + vol_t'(1);
        if ((cur > tgt) && (cur != VOL_MIN)) return cur - vol_t'(1);
        return cur;
    endfunction

endpackage

// File: rtl/ikaopll_accdac_fifo.sv
// Sample FIFO: head visible one cycle after push, valid/ready pop, push on full
// succeeds only when a pop happens on the same edge; otherwise the caller drops it.
module ikaopll_accdac_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_rdy_i,
    output logic         pop_vld_o,
    output logic [W-1:0] pop_dat_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         pop, push_ok;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_vld_o = ~empty_o;
    assign pop_dat_o = mem_q[rd_q[AW-1:0]];

    assign pop     = pop_vld_o & pop_rdy_i;
    assign push_ok = push_vld_i & (~full_o | pop);

    always_comb begin
        wr_d = wr_q + {{AW{1'b0}}, push_ok};
        rd_d = rd_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/ikaopll_accdac_ctrl.sv
// Volume/sample controller for the accumulating DAC; volume ramping builds only with IKAOPLL_ACCDAC_VOLRAMP_EN.
// Volume changes land on frame events only; samples appear one cycle after push, new samples dropped (sticky o_OVF) when full.
module ikaopll_accdac_ctrl
    import ikaopll_accdac_pkg::*;
#(
    parameter int   FIFO_DEPTH = 4,
    parameter vol_t RST_VOL    = 5'sd4
) (
    input  logic               i_EMUCLK,
    input  logic               i_RST_n,
    input  logic               i_phi1_NCEN_n,
    input  logic               i_VOL_WR,
    input  logic               i_VOL_SEL,
    input  logic signed [4:0]  i_VOL_DATA,
    output logic signed [4:0]  o_ACC_SIGNED_MOVOL,
    output logic signed [4:0]  o_ACC_SIGNED_ROVOL,
    input  logic               i_ACC_SIGNED_STRB,
    input  logic signed [15:0] i_ACC_SIGNED,
    output logic               o_SMPL_VALID,
    output logic signed [15:0] o_SMPL_DATA,
    input  logic               i_SMPL_READY,
    output logic               o_OVF,
    input  logic               i_OVF_CLR,
    output logic               o_RAMP_BUSY
);

    logic        strb_q, ovf_q;
    logic        frame, pop, ovf_set;
    logic        fifo_vld, fifo_full, fifo_empty;
    logic [15:0] fifo_dat;
    vol_t        target_q [2];
    vol_t        target_d [2];
    vol_t        applied_q [2];
    vol_t        applied_d [2];

    assign frame   = ~i_phi1_NCEN_n & i_ACC_SIGNED_STRB & ~strb_q;
    assign pop     = fifo_vld & i_SMPL_READY;
    assign ovf_set = frame & fifo_full & ~pop;

    assign o_ACC_SIGNED_MOVOL = applied_q[0];
    assign o_ACC_SIGNED_ROVOL = applied_q[1];
    assign o_SMPL_VALID       = fifo_vld;
    assign o_SMPL_DATA        = fifo_empty ? '0 : $signed(fifo_dat);
    assign o_OVF              = ovf_q;

    always_comb begin
        for (int ch = 0; ch < 2; ch++) target_d[ch] = target_q[ch];
        if (i_VOL_WR) target_d[i_VOL_SEL] = i_VOL_DATA;
    end

`ifdef IKAOPLL_ACCDAC_VOLRAMP_EN
    ch_state_e state_q [2];
    ch_state_e state_d [2];

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch]   = state_q[ch];
            applied_d[ch] = applied_q[ch];
            case (state_q[ch])
                STEADY: if (target_q[ch] != applied_q[ch]) state_d[ch] = RAMP;
                RAMP: begin
                    if (frame) begin
                        applied_d[ch] = step_toward(applied_q[ch], target_q[ch]);
                        if (step_toward(applied_q[ch], target_q[ch]) == target_q[ch])
                            state_d[ch] = STEADY;
                    end
                end
                default: state_d[ch] = STEADY;
            endcase
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            for (int ch = 0; ch < 2; ch++) state_q[ch] <= STEADY;
        end else begin
            for (int ch = 0; ch < 2; ch++) state_q[ch] <= state_d[ch];
        end
    end

    assign o_RAMP_BUSY = (state_q[0] == RAMP) | (state_q[1] == RAMP);
`else
    always_comb begin
        for (int ch = 0; ch < 2; ch++) applied_d[ch] = frame ? target_q[ch] : applied_q[ch];
    end

    assign o_RAMP_BUSY = 1'b0;
`endif

    // Strobe history only advances on enabled cycles so edges are seen in the phi1 domain.
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            strb_q <= 1'b0;
            ovf_q  <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                target_q[ch]  <= RST_VOL;
                applied_q[ch] <= RST_VOL;
            end
        end else begin
            if (!i_phi1_NCEN_n) strb_q <= i_ACC_SIGNED_STRB;
            ovf_q <= ovf_set | (ovf_q & ~i_OVF_CLR);
            for (int ch = 0; ch < 2; ch++) begin
                target_q[ch]  <= target_d[ch];
                applied_q[ch] <= applied_d[ch];
            end
        end
    end

    ikaopll_accdac_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_fifo (
        .clk_i      (i_EMUCLK),
        .rst_n_i    (i_RST_n),
        .push_vld_i (frame),
        .push_dat_i (i_ACC_SIGNED),
        .pop_rdy_i  (i_SMPL_READY),
        .pop_vld_o  (fifo_vld),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

endmodule

// File: tb/tb_ikaopll_accdac_ctrl.sv
// Directed bench for ikaopll_accdac_ctrl with a sample scoreboard; expectations
// follow IKAOPLL_ACCDAC_VOLRAMP_EN when it is defined for the build.
module tb_ikaopll_accdac_ctrl;

`ifdef IKAOPLL_ACCDAC_VOLRAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               ncen = 1'b0;
    logic               vol_wr = 1'b0;
    logic               vol_sel = 1'b0;
    logic signed [4:0]  vol_data = '0;
    logic               strb = 1'b0;
    logic signed [15:0] acc = '0;
    logic               rdy = 1'b0;
    logic               ovf_clr = 1'b0;
    logic signed [4:0]  mo, ro;
    logic               smpl_vld, ovf, busy;
    logic signed [15:0] smpl_dat;

    int                 checks = 0;
    int                 errors = 0;
    logic signed [15:0] sb [$];
    logic               exp_ovf = 1'b0;

    always #5 clk = ~clk;

    ikaopll_accdac_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .RST_VOL    (5'sd4)
    ) dut (
        .i_EMUCLK           (clk),
        .i_RST_n            (rst_n),
        .i_phi1_NCEN_n      (ncen),
        .i_VOL_WR           (vol_wr),
        .i_VOL_SEL          (vol_sel),
        .i_VOL_DATA         (vol_data),
        .o_ACC_SIGNED_MOVOL (mo),
        .o_ACC_SIGNED_ROVOL (ro),
        .i_ACC_SIGNED_STRB  (strb),
        .i_ACC_SIGNED       (acc),
        .o_SMPL_VALID       (smpl_vld),
        .o_SMPL_DATA        (smpl_dat),
        .i_SMPL_READY       (rdy),
        .o_OVF              (ovf),
        .i_OVF_CLR          (ovf_clr),
        .o_RAMP_BUSY        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_vol(input logic sel, input logic signed [4:0] v);
        vol_wr = 1'b1; vol_sel = sel; vol_data = v;
        tick();
        vol_wr = 1'b0;
    endtask

    // Frame with host not ready: model accepts while room remains, else flags overflow.
    task automatic frame(input logic signed [15:0] s);
        if (sb.size() < DEPTH) sb.push_back(s);
        else exp_ovf = 1'b1;
        strb = 1'b1; acc = s;
        tick();
        strb = 1'b0;
        tick();
    endtask

    task automatic pop_one(input string tag);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, observed valid %0d data %0d", tag, smpl_vld, smpl_dat);
        end else begin
            check({tag, "_vld"}, smpl_vld, 1);
            check({tag, "_dat"}, smpl_dat, sb[0]);
            rdy = 1'b1;
            tick();
            rdy = 1'b0;
            void'(sb.pop_front());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed checks %0d expected completion", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mo", mo, 4);
        check("rst_ro", ro, 4);
        check("rst_vld", smpl_vld, 0);
        check("rst_dat", smpl_dat, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Two frames after reset: volumes unchanged, two samples queued.
        frame(16'sd11);
        frame(16'sd22);
        check("f2_mo", mo, 4);
        check("f2_ro", ro, 4);
        check("f2_ovf", ovf, exp_ovf);
        pop_one("f2_pop0");
        pop_one("f2_pop1");
        check("f2_drained", smpl_vld, 0);

        // Strobe edge while the clock enable is inactive is ignored.
        ncen = 1'b1; strb = 1'b1; acc = 16'sd77;
        tick();
        strb = 1'b0;
        tick();
        ncen = 1'b0;
        tick();
        check("ncen_gate", smpl_vld, 0);

        // RO write overwritten before any frame; MO heads to -2.
        write_vol(1'b1, 5'sd7);
        write_vol(1'b1, 5'sd3);
        write_vol(1'b0, -5'sd2);
        tick();
        check("wr_busy", busy, RAMP);
        check("wr_mo_hold", mo, 4);
        for (int i = 0; i < 6; i++) begin
            frame(16'(200 + i));
            check("ramp_mo", mo, RAMP ? (3 - i) : -2);
            check("ramp_ro", ro, 3);
            check("ramp_busy", busy, (RAMP && (i < 5)) ? 1 : 0);
            pop_one("ramp_pop");
        end

        // Overflow: five frames with no reader.
        for (int i = 0; i < 5; i++) frame(16'(100 + i));
        check("ovf_set", ovf, exp_ovf);
        for (int i = 0; i < 4; i++) pop_one("ovf_pop");
        check("ovf_drained", smpl_vld, 0);
        check("ovf_sticky", ovf, exp_ovf);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_clr", ovf, exp_ovf);

        // Full FIFO with a pop on the frame edge: both succeed.
        for (int i = 0; i < 4; i++) frame(16'(100 + i));
        check("full_ovf", ovf, exp_ovf);
        check("full_head", smpl_dat, sb[0]);
        strb = 1'b1; acc = 16'sd104; rdy = 1'b1;
        tick();
        strb = 1'b0; rdy = 1'b0;
        void'(sb.pop_front());
        sb.push_back(16'sd104);
        tick();
        check("pp_ovf", ovf, exp_ovf);
        for (int i = 0; i < 4; i++) pop_one("pp_pop");

        // Clear and new overflow on the same edge: flag stays set.
        for (int i = 0; i < 4; i++) frame(16'(500 + i));
        strb = 1'b1; acc = 16'sd504; ovf_clr = 1'b1;
        tick();
        strb = 1'b0; ovf_clr = 1'b0;
        exp_ovf = 1'b1;
        tick();
        check("clr_vs_ovf", ovf, exp_ovf);

        // Reset with a full FIFO.
        rst_n = 1'b0;
        #1;
        check("rst2_vld", smpl_vld, 0);
        check("rst2_ovf", ovf, 0);
        sb.delete();
        exp_ovf = 1'b0;
        rst_n = 1'b1;
        tick();

        // Reset mid-ramp with three samples queued.
        write_vol(1'b0, -5'sd2);
        tick();
        for (int i = 0; i < 3; i++) frame(16'(300 + i));
        check("mid_mo", mo, RAMP ? 1 : -2);
        check("mid_busy", busy, RAMP);
        check("mid_vld", smpl_vld, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_mo", mo, 4);
        check("async_ro", ro, 4);
        check("async_vld", smpl_vld, 0);
        check("async_dat", smpl_dat, 0);
        check("async_busy", busy, 0);
        sb.delete();
        exp_ovf = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        frame(16'sd400);
        check("post_mo", mo, 4);
        check("post_busy", busy, 0);
        pop_one("post_pop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
